// File: rtl/neuron_pkg.sv
// Shared types and constants for the neuron datapath: operand widths,
// frame geometry and the input loader state encoding.
package neuron_pkg;

    localparam int N_IN   = 8;
    localparam int W_DATA = 8;
    localparam int W_CNT  = 16;
    localparam int W_IDX  = $clog2(N_IN);

    typedef logic [W_DATA-1:0]  operand_t;
    typedef operand_t [N_IN-1:0] operand_arr_t;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        FULL = 1'b1
    } loader_state_t;

    localparam logic [W_IDX-1:0] IDX_LAST = W_IDX'(N_IN - 1);

    // True when the write index points at the final slot of a frame.
    function automatic logic is_last_idx(input logic [W_IDX-1:0] idx);
        return (idx == IDX_LAST);
    endfunction

endpackage

// File: rtl/neuron_in_loader_if.sv
// Byte-stream valid/ready handshake feeding the neuron input loader.
// DIN_READY never depends on DIN_VALID, so the producer must not gate valid on ready.
interface neuron_in_loader_if;
    import neuron_pkg::*;

    operand_t DIN;
    logic     DIN_VALID;
    logic     DIN_LAST;
    logic     DIN_READY;

    modport master (
        output DIN,
        output DIN_VALID,
        output DIN_LAST,
        input  DIN_READY
    );

    modport slave (
        input  DIN,
        input  DIN_VALID,
        input  DIN_LAST,
        output DIN_READY
    );

endinterface

// File: rtl/neuron_in_fillbuf.sv
// Indexed fill buffer for one frame: writes land at the running index, and
// full flags the write that completes the frame.
module neuron_in_fillbuf
    import neuron_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic             clr,
    input  operand_t         wr_data,
    output operand_arr_t     fill,
    output logic [W_IDX-1:0] idx,
    output logic             full
);

    operand_arr_t     fill_r;
    logic [W_IDX-1:0] idx_r;

    // Buffer storage and write index; clr abandons a partial frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_r <= '0;
            idx_r  <= '0;
        end else if (clr) begin
            idx_r <= '0;
        end else if (wr_en) begin
            fill_r[idx_r] <= wr_data;
            if (is_last_idx(idx_r)) begin
                idx_r <= '0;
            end else begin
                idx_r <= idx_r + W_IDX'(1);
            end
        end
    end

    assign fill = fill_r;
    assign idx  = idx_r;
    assign full = wr_en && is_last_idx(idx_r);

endmodule

// File: rtl/neuron_in_loader.sv
// Double-buffered frame loader: streams bytes into the fill buffer and, on
// UPDATE, commits the completed frame onto the registered operands D0..D7.
module neuron_in_loader
    import neuron_pkg::*;
(
    input  logic                CK1,
    input  logic                RSTN,
    neuron_in_loader_if.slave   din_if,
    input  logic                UPDATE,
    output operand_t            D0,
    output operand_t            D1,
    output operand_t            D2,
    output operand_t            D3,
    output operand_t            D4,
    output operand_t            D5,
    output operand_t            D6,
    output operand_t            D7,
    output logic                D_VALID,
    output logic                ERR,
    output logic [W_CNT-1:0]    FRAME_CNT
);

    loader_state_t    state_r;
    loader_state_t    state_nxt_s;
    operand_arr_t     d_r;
    operand_arr_t     fill_s;
    logic [W_IDX-1:0] idx_s;
    logic             d_valid_r;
    logic             err_r;
    logic [W_CNT-1:0] frame_cnt_r;
    logic             ready_s;
    logic             accept_s;
    logic             drop_s;
    logic             wr_en_s;
    logic             len_err_s;
    logic             full_s;
    logic             commit_s;

    // Handshake qualification and frame-length checks on the accepted byte.
    always_comb begin
        ready_s   = 1'b1;
        accept_s  = 1'b0;
        drop_s    = 1'b0;
        wr_en_s   = 1'b0;
        len_err_s = 1'b0;
        if (state_r == FULL) begin
            ready_s = UPDATE;
        end else begin
            ready_s = 1'b1;
        end
        accept_s  = din_if.DIN_VALID && ready_s;
        drop_s    = accept_s && din_if.DIN_LAST && !is_last_idx(idx_s);
        wr_en_s   = accept_s && !drop_s;
        len_err_s = drop_s || (wr_en_s && is_last_idx(idx_s) && !din_if.DIN_LAST);
    end

    neuron_in_fillbuf u_fillbuf (
        .clk     (CK1),
        .rst_n   (RSTN),
        .wr_en   (wr_en_s),
        .clr     (drop_s),
        .wr_data (din_if.DIN),
        .fill    (fill_s),
        .idx     (idx_s),
        .full    (full_s)
    );

    // Next-state and commit decode; a byte accepted during commit restarts filling.
    always_comb begin
        state_nxt_s = state_r;
        commit_s    = 1'b0;
        case (state_r)
            FILL: begin
                if (full_s) begin
                    state_nxt_s = FULL;
                end else begin
                    state_nxt_s = FILL;
                end
            end
            FULL: begin
                commit_s = UPDATE;
                if (UPDATE) begin
                    state_nxt_s = FILL;
                end else begin
                    state_nxt_s = FULL;
                end
            end
            default: begin
                state_nxt_s = FILL;
            end
        endcase
    end

    // State register.
    always_ff @(posedge CK1 or negedge RSTN) begin
        if (!RSTN) begin
            state_r <= FILL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Committed operands, commit pulse, sticky error and frame counter.
    always_ff @(posedge CK1 or negedge RSTN) begin
        if (!RSTN) begin
            d_r         <= '0;
            d_valid_r   <= 1'b0;
            err_r       <= 1'b0;
            frame_cnt_r <= '0;
        end else begin
            d_valid_r <= commit_s;
            if (commit_s) begin
                d_r         <= fill_s;
                frame_cnt_r <= frame_cnt_r + W_CNT'(1);
            end
            if (len_err_s) begin
                err_r <= 1'b1;
            end
        end
    end

    assign din_if.DIN_READY = ready_s;
    assign D0        = d_r[0];
    assign D1        = d_r[1];
    assign D2        = d_r[2];
    assign D3        = d_r[3];
    assign D4        = d_r[4];
    assign D5        = d_r[5];
    assign D6        = d_r[6];
    assign D7        = d_r[7];
    assign D_VALID   = d_valid_r;
    assign ERR       = err_r;
    assign FRAME_CNT = frame_cnt_r;

endmodule

// File: tb/tb_neuron_in_loader.sv
// Directed bench for neuron_in_loader with a frame scoreboard and a small
// reference model of the fill/commit behaviour.
module tb_neuron_in_loader;
    import neuron_pkg::*;

    logic             CK1 = 1'b0;
    logic             RSTN = 1'b0;
    logic             UPDATE = 1'b0;
    operand_t         D0, D1, D2, D3, D4, D5, D6, D7;
    logic             D_VALID;
    logic             ERR;
    logic [W_CNT-1:0] FRAME_CNT;
    logic [63:0]      d_obs;

    neuron_in_loader_if din_if ();

    neuron_in_loader dut (
        .CK1       (CK1),
        .RSTN      (RSTN),
        .din_if    (din_if),
        .UPDATE    (UPDATE),
        .D0        (D0),
        .D1        (D1),
        .D2        (D2),
        .D3        (D3),
        .D4        (D4),
        .D5        (D5),
        .D6        (D6),
        .D7        (D7),
        .D_VALID   (D_VALID),
        .ERR       (ERR),
        .FRAME_CNT (FRAME_CNT)
    );

    always #5 CK1 = ~CK1;

    assign d_obs = {D7, D6, D5, D4, D3, D2, D1, D0};

    int          n_assert = 0;
    int          n_fail   = 0;
    logic [63:0] exp_q[$];
    logic [7:0]  m_fill[8];
    int          m_idx;
    logic        m_full;
    logic        m_err;
    logic        m_dv;
    logic [15:0] m_cnt;
    logic [63:0] m_d;
    int          n_dv = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] pack_fill();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) r[i*8 +: 8] = m_fill[i];
        return r;
    endfunction

    task automatic reset_model();
        for (int i = 0; i < 8; i++) m_fill[i] = 8'h00;
        m_idx  = 0;
        m_full = 1'b0;
        m_err  = 1'b0;
        m_dv   = 1'b0;
        m_cnt  = 16'h0000;
        m_d    = 64'h0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, check ready, advance the model, check outputs.
    task automatic step(input logic v, input logic l, input logic [7:0] d, input logic u);
        logic exp_ready;
        logic acc;
        logic commit;
        din_if.DIN       = d;
        din_if.DIN_VALID = v;
        din_if.DIN_LAST  = l;
        UPDATE           = u;
        #1;
        exp_ready = m_full ? u : 1'b1;
        chk("din_ready", 64'(din_if.DIN_READY), 64'(exp_ready));
        acc    = v && exp_ready;
        commit = m_full && u;
        @(posedge CK1);
        m_dv = commit;
        if (commit) begin
            m_cnt  = m_cnt + 16'h0001;
            m_full = 1'b0;
        end
        if (acc) begin
            if (l && m_idx != 7) begin
                m_err = 1'b1;
                m_idx = 0;
            end else begin
                m_fill[m_idx] = d;
                if (m_idx == 7) begin
                    if (!l) m_err = 1'b1;
                    exp_q.push_back(pack_fill());
                    m_full = 1'b1;
                    m_idx  = 0;
                end else begin
                    m_idx++;
                end
            end
        end
        #1;
        chk("d_valid", 64'(D_VALID), 64'(m_dv));
        if (D_VALID) begin
            n_dv++;
            chk("sb_has_frame", 64'(exp_q.size() != 0), 64'h1);
            if (exp_q.size() != 0) begin
                m_d = exp_q.pop_front();
                chk("d_frame", d_obs, m_d);
            end
        end else begin
            chk("d_hold", d_obs, m_d);
        end
        chk("err", 64'(ERR), 64'(m_err));
        chk("frame_cnt", 64'(FRAME_CNT), 64'(m_cnt));
    endtask

    task automatic send_frame(input logic [7:0] base, input int n, input int last_pos, input logic u);
        for (int i = 0; i < n; i++) step(1'b1, (i == last_pos), 8'(base + 8'(i)), u);
    endtask

    initial begin
        int          n0;
        logic [15:0] c0;
        reset_model();
        din_if.DIN       = 8'h00;
        din_if.DIN_VALID = 1'b0;
        din_if.DIN_LAST  = 1'b0;
        repeat (2) @(posedge CK1);
        #1;
        chk("rst_d", d_obs, 64'h0);
        chk("rst_dvalid", 64'(D_VALID), 64'h0);
        chk("rst_err", 64'(ERR), 64'h0);
        chk("rst_cnt", 64'(FRAME_CNT), 64'h0);
        chk("rst_ready", 64'(din_if.DIN_READY), 64'h1);
        @(negedge CK1);
        RSTN = 1'b1;
        @(posedge CK1);
        #1;

        // Basic frame, commit one edge after the 8th byte
        send_frame(8'h01, 8, 7, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t1_frame", d_obs, 64'h0807060504030201);
        chk("t1_cnt", 64'(FRAME_CNT), 64'h1);
        chk("t1_pulses", 64'(n_dv), 64'h1);

        // Held full frame, then commit concurrent with the next frame's first byte
        send_frame(8'h21, 8, 7, 1'b0);
        repeat (5) step(1'b1, 1'b0, 8'hAA, 1'b0);
        step(1'b1, 1'b0, 8'hAA, 1'b1);
        chk("t2_frame", d_obs, 64'h2827262524232221);
        send_frame(8'hAB, 7, 6, 1'b0);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t2_aa_first", d_obs, 64'hB1B0AFAEADACABAA);

        // 20 back-to-back frames at one byte per cycle
        n0 = n_dv;
        c0 = m_cnt;
        for (int i = 0; i < 160; i++) step(1'b1, (i % 8 == 7), 8'(i), 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t3_pulses", 64'(n_dv - n0), 64'd20);
        chk("t3_cnt", 64'(FRAME_CNT), 64'(c0 + 16'd20));
        chk("t3_err", 64'(ERR), 64'h0);
        chk("t3_last_frame", d_obs, 64'h9F9E9D9C9B9A9998);

        // Short frame: LAST on 5th byte
        send_frame(8'h30, 5, 4, 1'b1);
        chk("t4_err", 64'(ERR), 64'h1);
        send_frame(8'h10, 8, 7, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t4_frame", d_obs, 64'h1716151413121110);

        // Missing LAST still commits; counter wraps from all-ones
        send_frame(8'h40, 8, -1, 1'b0);
        chk("t5_err", 64'(ERR), 64'h1);
        force dut.frame_cnt_r = 16'hFFFF;
        #1;
        release dut.frame_cnt_r;
        m_cnt = 16'hFFFF;
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t5_cnt_wrap", 64'(FRAME_CNT), 64'h0);
        chk("t5_frame", d_obs, 64'h4746454443424140);

        // Asynchronous reset mid-frame
        send_frame(8'h50, 3, -1, 1'b0);
        din_if.DIN_VALID = 1'b0;
        #3;
        RSTN = 1'b0;
        #1;
        chk("t6_rst_d", d_obs, 64'h0);
        chk("t6_rst_dvalid", 64'(D_VALID), 64'h0);
        chk("t6_rst_err", 64'(ERR), 64'h0);
        chk("t6_rst_cnt", 64'(FRAME_CNT), 64'h0);
        chk("t6_rst_ready", 64'(din_if.DIN_READY), 64'h1);
        reset_model();
        #2;
        RSTN = 1'b1;
        @(posedge CK1);
        #1;
        send_frame(8'h60, 8, 7, 1'b1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("t6_frame", d_obs, 64'h6766656463626160);
        chk("t6_cnt", 64'(FRAME_CNT), 64'h1);
        chk("sb_drained", 64'(exp_q.size()), 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/neuron_in_loader.md
# neuron_in_loader

Upstream feeder for the neuron datapath. It collects a byte stream over a valid/ready handshake into an 8-entry fill buffer. On a downstream UPDATE strobe it commits the completed frame in parallel onto D0..D7, the operands the neuron samples each CK1 period. It provides double buffering, so the next frame streams in while the current one is held stable, and it flags malformed frame lengths.

## Interface
- N_IN, 8, number of neuron inputs / bytes per frame
- W_DATA, 8, bits per input
- W_CNT, 16, width of committed-frame counter
- CK1  in  1  the only clock; all state changes on posedge CK1
- RSTN  in  1  reset, asynchronous and active-low
- DIN  in  W_DATA  stream byte
- DIN_VALID  in  1  DIN holds a valid byte
- DIN_LAST  in  1  marks the final byte of a frame; qualified by DIN_VALID
- DIN_READY  out  1  loader accepts DIN this cycle
- UPDATE  in  1  downstream permission to commit a full frame onto D0..D7
- D0..D7  out  W_DATA each  committed operands to the neuron
- D_VALID  out  1  one-cycle pulse, the cycle after D0..D7 change
- ERR  out  1  sticky frame-length error
- FRAME_CNT  out  W_CNT  number of committed frames

## Operation
- The block has one clock, CK1. Reset is asynchronous and active-low on RSTN. While RSTN is low, all state clears immediately.
- Reset values:
  - D0..D7 = 0, D_VALID = 0, ERR = 0, FRAME_CNT = 0.
  - State = FILL, index = 0, so DIN_READY = 1.
- Accept: a byte is accepted when DIN_VALID && DIN_READY at a posedge. It is written to fill[index], and index increments.
  - Byte order: the first byte of a frame goes to D0, the eighth to D7.
- State machine, 2 states:
  - FILL: DIN_READY = 1. The 8th accepted byte (index 7) moves the state to FULL and resets index to 0.
  - FULL: the fill buffer is complete and holds. DIN_READY = UPDATE (combinational).
    - UPDATE = 1: fill[0..7] copies to D0..D7, FRAME_CNT increments, and D_VALID asserts in the next cycle.
    - The next state is FILL, unless a byte is accepted in the same cycle. In that case the byte is written to fill[0], index becomes 1, and the state goes to FILL.
    - UPDATE = 0: the state stays FULL and D0..D7 are unchanged.
- Length checks:
  - DIN_LAST with index != 7: ERR sets, the partial frame is discarded, index returns to 0, and the state stays FILL. The byte carrying LAST is dropped.
  - Index 7 accepted without DIN_LAST: ERR sets, but the frame is still treated as complete and goes to FULL.
- ERR clears only on reset.
- FRAME_CNT wraps modulo 2^W_CNT without saturation.
- UPDATE in FILL has no effect, and D0..D7 hold.
- Reset mid-frame: the partial frame is lost, outputs zero, and no D_VALID pulse is generated.

## Timing
- Byte to FULL: the 8th byte accepted at edge k gives state FULL after edge k.
- Commit latency: the earliest commit is edge k+1, when UPDATE is high then. D0..D7 are new after edge k+1, and D_VALID is high for the one cycle following edge k+1.
- Back-to-back frames sustain 1 byte/cycle when UPDATE is held high. One frame commits every 8 cycles with no bubbles.
- D0..D7 change only on commit edges and are glitch-free registered outputs. They are stable for at least 8 cycles between commits.
- DIN_READY is combinational from state and UPDATE only, with no path from DIN_VALID. The upstream side must not make DIN_VALID depend on DIN_READY.
- D_VALID, ERR and FRAME_CNT are registered.

## Structure
- Shared package neuron_pkg:
  - N_IN, W_DATA constants;
  - typedef operand_t (logic [W_DATA-1:0]);
  - typedef operand_arr_t (operand_t [N_IN-1:0]);
  - enum loader_state_t {FILL, FULL}.
- neuron_pkg is also imported by the neuron reference and circuit-model wrappers.
- One sub-module, neuron_in_fillbuf, holds the indexed write buffer with an index counter and a full flag. The top level holds the FSM, output registers, ERR and FRAME_CNT.

## Test plan
- Reset, then stream 8'h01..8'h08 with LAST on the 8th byte and UPDATE = 1 → D0 = 01 … D7 = 08 one edge after the 8th byte, a single D_VALID pulse, FRAME_CNT = 1.
- Full frame with UPDATE held 0 for 5 cycles → DIN_READY = 0 and D0..D7 unchanged. Raise UPDATE while DIN_VALID is high with 8'hAA → commit occurs, and AA lands in fill[0] of the next frame.
- 20 continuous frames with UPDATE = 1 and DIN_VALID = 1 → one commit every 8 cycles, FRAME_CNT = 20, no dropped bytes, ERR = 0.
- LAST on the 5th byte → ERR = 1 and the partial frame is discarded. The next 8 bytes 8'h10..8'h17 commit correctly as D0 = 10 … D7 = 17.
- 8th byte without LAST → ERR = 1 and the frame still commits. Preload FRAME_CNT to 16'hFFFF via a forced value, then commit once → FRAME_CNT = 0.
- Assert RSTN low mid-frame after 3 bytes, asynchronously between edges → outputs are 0 immediately. A fresh 8-byte frame afterwards commits with no leftover bytes.
